// File: rtl/datapath_mc_if.sv
// Instruction-memory req/ack fetch bus between datapath_mc (master) and the
// instruction memory (slave).
interface datapath_mc_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/datapath_mc.sv
// Multicycle RISC datapath: req/ack instruction fetch, FETCH/DECODE/EXECUTE/WRITEBACK
// sequencing, 4-entry register file. Define DATAPATH_MC_CARRY_EN for carry tracking and ADC.
module datapath_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    datapath_mc_if.master     imem,
    output logic [7:0]        instruction,
    output logic [DATA_W-1:0] alu_result,
    output logic [PC_W-1:0]   pc_value,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              halted,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              req_q;
    logic [3:0]        opcode;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic              is_alu;
    logic              take_branch;
    logic [DATA_W:0]   alu_val;
    logic [PC_W-1:0]   branch_off;

    assign opcode      = instruction[7:4];
    assign rd          = instruction[3:2];
    assign rs          = instruction[1:0];
    assign branch_off  = {{(PC_W-4){instruction[3]}}, instruction[3:0]};
    assign take_branch = (opcode == 4'h9) || (opcode == 4'h8 && zero_flag);

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_value;
    assign dbg_data       = regs[dbg_sel];

`ifdef DATAPATH_MC_CARRY_EN
    logic carry_q;
    assign is_alu     = (opcode >= 4'h1 && opcode <= 4'h7) || opcode == 4'hA;
    assign carry_flag = carry_q;
`else
    logic unused_carry;
    assign is_alu       = (opcode >= 4'h1 && opcode <= 4'h7);
    assign carry_flag   = 1'b0;
    assign unused_carry = alu_val[DATA_W];
`endif

    // Top bit of alu_val is the carry/borrow; logic ops leave it clear.
    always_comb begin
        alu_val = {1'b0, op_a};
        case (opcode)
            4'h1: alu_val = {1'b0, op_a} + {1'b0, op_b};
            4'h2: alu_val = {1'b0, op_a} - {1'b0, op_b};
            4'h3: alu_val = {1'b0, op_a & op_b};
            4'h4: alu_val = {1'b0, op_a | op_b};
            4'h5: alu_val = {1'b0, op_a ^ op_b};
            4'h6: alu_val = {1'b0, op_a} + (DATA_W+1)'(1);
            4'h7: alu_val = {op_a, 1'b0};
`ifdef DATAPATH_MC_CARRY_EN
            4'hA: alu_val = {1'b0, op_a} + {1'b0, op_b} + (DATA_W+1)'(carry_q);
`endif
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = FETCH;
            FETCH:     if (imem.imem_ack) next_state = DECODE;
            DECODE:    next_state = EXECUTE;
            EXECUTE:   next_state = WRITEBACK;
            WRITEBACK: next_state = (opcode == 4'hF) ? HALT : FETCH;
            HALT:      next_state = HALT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // The request is registered from next_state so it rises on entry to FETCH
    // and drops on the same edge that samples the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q       <= 1'b0;
            instruction <= '0;
            pc_value    <= '0;
            alu_result  <= '0;
            zero_flag   <= 1'b0;
            halted      <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            req_q <= (next_state == FETCH);
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instruction <= imem.imem_rdata;
                        pc_value    <= pc_value + PC_W'(1);
                    end
                end
                DECODE: begin
                    op_a <= regs[rd];
                    op_b <= regs[rs];
                end
                EXECUTE: begin
                    if (is_alu) begin
                        alu_result <= alu_val[DATA_W-1:0];
                        zero_flag  <= (alu_val[DATA_W-1:0] == '0);
                    end
                end
                WRITEBACK: begin
                    if (is_alu)             regs[rd] <= alu_result;
                    if (take_branch)        pc_value <= pc_value + branch_off;
                    if (opcode == 4'hF)     halted   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DATAPATH_MC_CARRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              carry_q <= 1'b0;
        else if (state == EXECUTE && is_alu)   carry_q <= alu_val[DATA_W];
    end
`endif
endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised multicycle successor to the single-cycle RISC datapath. It fetches 8-bit instructions over a req/ack memory handshake and executes them through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. It has a 4-entry register file, zero/carry flags, relative branches and HALT. It sits between the instruction memory and the CPU top, and exposes PC, instruction and ALU result for the bench as its predecessor did.

## Interface
- DATA_W, 8, register/ALU width (≥4)
- PC_W, 8, program counter and imem address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request, registered
- imem_addr  output  PC_W  fetch address, equal to pc_value while imem_req=1
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  8  instruction byte
- instruction  output  8  last latched instruction
- alu_result  output  DATA_W  last ALU result, registered
- pc_value  output  PC_W  program counter
- zero_flag  output  1  ALU result was zero
- carry_flag  output  1  carry/borrow (see Configuration)
- halted  output  1  HALT executed
- dbg_sel  input  2  register select for debug read
- dbg_data  output  DATA_W  combinational read of reg[dbg_sel]

## Operation
- Instruction format: op[7:4], rd[3:2], rs[1:0]; off4 = instr[3:0] sign-extended.
- Ops:
  - 0 NOP
  - 1 ADD rd=rd+rs
  - 2 SUB rd=rd−rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 INC rd=rd+1
  - 7 SHL rd=rd<<1, with carry = old MSB
  - 8 BRZ: if zero_flag, PC=PC+off4
  - 9 JMP: PC=PC+off4
  - A ADC (only when the macro is defined)
  - F HALT
  - B–E, and A without the macro: NOP
- ALU arithmetic is DATA_W wide. Results are truncated modulo 2^DATA_W. Carry is bit DATA_W of the sum; for SUB it is the borrow.
- Flags: ops 1–7 (and ADC) update zero_flag and alu_result. NOP, branches and HALT leave both flags and alu_result unchanged. AND/OR/XOR clear carry.
- PC increments modulo 2^PC_W on fetch ack. The branch target is the incremented PC + off4, modulo 2^PC_W.
- States:
  - IDLE → FETCH unconditionally.
  - FETCH waits for imem_ack, then latches instruction, increments PC and goes to DECODE.
  - DECODE reads rd/rs into operand registers → EXECUTE.
  - EXECUTE computes the result and flags → WRITEBACK.
  - WRITEBACK writes rd (ops 1–7, A), updates PC on a taken branch, then → FETCH. For HALT it goes → HALT.
- HALT: halted=1 and imem_req=0. It exits only via reset.
- Reset (asynchronous, any state, including mid-fetch) sets the following to zero:
  - state=IDLE
  - pc_value, instruction, alu_result, all registers
  - zero_flag, carry_flag, halted, imem_req

## Timing
- First clk edge after rst release: IDLE→FETCH. imem_req rises at that edge, and imem_addr=0.
- imem_req stays high and imem_addr stays stable until imem_ack is sampled high. imem_req is cleared at that same edge.
- imem_ack while imem_req=0 is ignored.
- The ack edge updates instruction and pc_value.
- alu_result and the flags update at the EXECUTE→WRITEBACK edge.
- The register write and branch PC update occur at the WRITEBACK→FETCH edge. imem_req reasserts at that edge with the new PC.
- Minimum 4 cycles per instruction with zero-wait memory (ack in the first FETCH cycle). Each extra wait cycle adds one.
- rs=rd is legal: operands are read in DECODE, before writeback.

## Configuration
- DATAPATH_MC_CARRY_EN defined:
  - carry_flag is tracked as above.
  - op A ADC computes rd=rd+rs+carry_flag and updates zero and carry.
- DATAPATH_MC_CARRY_EN undefined:
  - carry_flag is tied to 0.
  - op A decodes as NOP.
  - No carry storage is synthesised.

## Test plan
- Reset check: hold rst=0 for 20 ns, then release. All outputs are 0. One edge later imem_req=1 and imem_addr=0. Assert rst=0 during EXECUTE: all outputs return to 0 immediately.
- Arithmetic: program 0x60 (INC r0), 0x60, 0x14 (ADD r1,r0), zero-wait ack. Result: r1=2, alu_result=0x02, pc_value=3, and each instruction takes 4 cycles.
- Wrap/carry (macro on, DATA_W=8): set r1=1 and r2=0, then run 0x29 (SUB r2,r1). Result: r2=0xFF, carry=1, zero=0. Then 0x68 (INC r2): r2=0x00, zero=1, carry=1.
- Branch: SUB r0,r0 (0x20) at addr 5 gives zero=1. Then BRZ 0x8E at addr 6: next imem_addr=0x05 (7+(−2)). With zero=0, next imem_addr=0x07.
- Wait states: delay imem_ack by 3 cycles. imem_req and imem_addr hold stable, instruction is unchanged until the ack edge, and the total is 7 cycles for that instruction.
- HALT: fetch 0xF0. halted=1 four cycles after ack, imem_req stays 0 for ≥50 cycles, and dbg_data reads remain intact.
